// File: rtl/spart_pkg.sv
// Shared constants for the SPART receiver: register map, FSM encoding, status bits.
package spart_pkg;

  // Processor-side register addresses
  localparam logic [1:0] ADDR_RXBUF  = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  // Bit positions inside the status byte {5'b0, framing, overrun, rda}
  localparam int STAT_RDA = 0;
  localparam int STAT_OVR = 1;
  localparam int STAT_FRM = 2;

  // Receiver FSM encoding
  typedef enum logic [1:0] {
    RX_IDLE  = 2'b00,
    RX_START = 2'b01,
    RX_DATA  = 2'b10,
    RX_STOP  = 2'b11
  } rx_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator: down-counter that pulses tick_o for one cycle every div_i+1 clocks.
module spart_baud_gen #(
  parameter logic [15:0] DIV_RESET = 16'h028A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div_i,
  input  logic        load_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;

  // Tick on terminal count; a pending reload suppresses it so the new rate starts cleanly.
  assign tick_o = (cnt_q == 16'h0000) && !load_i;

  // Next count: explicit reload, wrap at zero, otherwise count down.
  always_comb begin
    cnt_d = cnt_q - 16'h0001;
    if (load_i || cnt_q == 16'h0000) cnt_d = div_i;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= DIV_RESET;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: programmable baud divisor, oversampled 8N1 receive FSM,
// single-byte receive buffer with rda/overrun/framing status on a shared bus.
module spart_rx
  import spart_pkg::*;
#(
  parameter int          OVERSAMPLE  = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] DIV_RESET   = 16'h028A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rxd,
  output logic       rda
);

  localparam logic [3:0] HALF_M1 = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] FULL_M1 = 4'(OVERSAMPLE - 1);

  // Bus decode
  logic wr_en, rd_en, rd_buf, rd_stat, div_wr;
  assign wr_en   = iocs && !iorw;
  assign rd_en   = iocs && iorw;
  assign rd_buf  = rd_en && (ioaddr == ADDR_RXBUF);
  assign rd_stat = rd_en && (ioaddr == ADDR_STATUS);
  assign div_wr  = wr_en && (ioaddr == ADDR_DIV_LO || ioaddr == ADDR_DIV_HI);

  // ---------------- divisor + baud generator ----------------
  logic [15:0] div_q, div_d;
  logic        load_q;
  logic        tick;

  // Byte-wise divisor update from processor writes.
  always_comb begin
    div_d = div_q;
    if (wr_en && ioaddr == ADDR_DIV_LO) div_d[7:0]  = databus;
    if (wr_en && ioaddr == ADDR_DIV_HI) div_d[15:8] = databus;
  end

  // Divisor register; load_q tells the baud counter to restart with the new value next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= DIV_RESET;
      load_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      load_q <= div_wr;
    end
  end

  spart_baud_gen #(.DIV_RESET(DIV_RESET)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .div_i  (div_q),
    .load_i (load_q),
    .tick_o (tick)
  );

  // ---------------- rxd synchronizer ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  assign rxd_s = sync_q[SYNC_STAGES-1];

  // Shift the raw line through SYNC_STAGES flops; idle-high reset avoids a phantom start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else begin
      sync_q[0] <= rxd;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // ---------------- receive FSM ----------------
  rx_state_e  state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       frame_ok, frame_err;

  // FSM state and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      tcnt_q  <= 4'd0;
      bcnt_q  <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: everything advances only on baud ticks; data is sampled mid-bit, LSB first.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    if (tick) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!rxd_s) begin
            state_d = RX_START;
            tcnt_d  = 4'd0;
          end
        end
        RX_START: begin
          if (tcnt_q == HALF_M1) begin
            state_d = rxd_s ? RX_IDLE : RX_DATA;
            tcnt_d  = 4'd0;
            bcnt_d  = 3'd0;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
        RX_DATA: begin
          if (tcnt_q == FULL_M1) begin
            shift_d = {rxd_s, shift_q[7:1]};
            tcnt_d  = 4'd0;
            if (bcnt_q == 3'd7) state_d = RX_STOP;
            else                bcnt_d  = bcnt_q + 3'd1;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
        RX_STOP: begin
          if (tcnt_q == FULL_M1) begin
            frame_ok  = rxd_s;
            frame_err = !rxd_s;
            state_d   = RX_IDLE;
            tcnt_d    = 4'd0;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // ---------------- receive buffer and status ----------------
  logic [7:0] rxbuf_q, rxbuf_d;
  logic       rda_q, rda_d, ovr_q, ovr_d, frm_q, frm_d;

  // A buffer read in the completion cycle frees the slot, so the new byte lands without overrun.
  always_comb begin
    rxbuf_d = rxbuf_q;
    rda_d   = rda_q;
    ovr_d   = ovr_q;
    frm_d   = frm_q;
    if (rd_buf)  rda_d = 1'b0;
    if (rd_stat) begin
      ovr_d = 1'b0;
      frm_d = 1'b0;
    end
    if (frame_ok) begin
      if (!rda_q || rd_buf) begin
        rxbuf_d = shift_q;
        rda_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (frame_err) frm_d = 1'b1;
  end

  // Buffer/status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxbuf_q <= 8'h00;
      rda_q   <= 1'b0;
      ovr_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      rxbuf_q <= rxbuf_d;
      rda_q   <= rda_d;
      ovr_q   <= ovr_d;
      frm_q   <= frm_d;
    end
  end

  assign rda = rda_q;

  // ---------------- read mux / bus driver ----------------
  logic [7:0] rdata;

  // Combinational read data for the addressed register.
  always_comb begin
    rdata = 8'h00;
    unique case (ioaddr)
      ADDR_RXBUF:  rdata = rxbuf_q;
      ADDR_STATUS: begin
        rdata[STAT_RDA] = rda_q;
        rdata[STAT_OVR] = ovr_q;
        rdata[STAT_FRM] = frm_q;
      end
      ADDR_DIV_LO: rdata = div_q[7:0];
      ADDR_DIV_HI: rdata = div_q[15:8];
      default:     rdata = 8'h00;
    endcase
  end

  assign databus = rd_en ? rdata : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_spart_rx.sv
// Directed + randomized bench for spart_rx with a transaction-level receive model.
module tb_spart_rx;

  localparam int CPB = 64;  // clocks per serial bit with divisor 3, oversample 16

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0, iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic       rxd = 1'b1;
  logic       rda;
  logic       drv_en = 1'b0;
  logic [7:0] drv_data = 8'h00;
  wire  [7:0] databus;

  assign databus = drv_en ? drv_data : 8'bzzzz_zzzz;

  spart_rx dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rxd(rxd), .rda(rda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int fstart = 0, lat = 0;
  bit in_frame = 0;

  // Behavioural model of the processor-visible state
  logic [7:0] m_buf = 8'h00;
  bit m_rda = 0, m_ovr = 0, m_frm = 0;

  function automatic logic [7:0] m_status();
    return {5'b0, m_frm, m_ovr, m_rda};
  endfunction

  function automatic void model_frame(logic [7:0] b, bit ok);
    if (!ok) m_frm = 1;
    else if (!m_rda) begin m_buf = b; m_rda = 1; end
    else m_ovr = 1;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cpu_rd(logic [1:0] a, output logic [7:0] d);
    iocs = 1; iorw = 1; ioaddr = a;
    @(negedge clk); d = databus;
    step();
    iocs = 0; iorw = 0;
  endtask

  task automatic cpu_wr(logic [1:0] a, logic [7:0] d);
    iocs = 1; iorw = 0; ioaddr = a; drv_en = 1; drv_data = d;
    step();
    iocs = 0; drv_en = 0;
  endtask

  // Reads a register, checks it against the model, then applies the read side effect.
  task automatic rd_chk(string tag, logic [1:0] a);
    logic [7:0] d, e;
    e = (a == 2'b00) ? m_buf : m_status();
    cpu_rd(a, d);
    chk(tag, d, e);
    if (a == 2'b00) m_rda = 0;
    else if (a == 2'b01) begin m_ovr = 0; m_frm = 0; end
  endtask

  // 8N1 frame aligned to a 4-clock grid so the baud phase is the same for every frame.
  task automatic send_frame(logic [7:0] b, bit stop_ok);
    while (cyc % 4 != 0) step();
    fstart = cyc; in_frame = 1;
    rxd = 0; repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (CPB) step(); end
    rxd = stop_ok; repeat (CPB) step();
    rxd = 1; in_frame = 0;
    repeat (2 * CPB) step();
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    bit ok, seen;
    int act;

    repeat (3) step();
    rst = 0;
    step();

    // Reset state
    chk("rst_rda", {7'b0, rda}, 8'h00);
    cpu_rd(2'b10, d); chk("rst_div_lo", d, 8'h8A);
    cpu_rd(2'b11, d); chk("rst_div_hi", d, 8'h02);
    rd_chk("rst_status", 2'b01);
    rd_chk("rst_rxbuf", 2'b00);

    // Program divisor 3 and read it back
    cpu_wr(2'b10, 8'h03);
    cpu_wr(2'b11, 8'h00);
    cpu_wr(2'b00, 8'hFF);  // ignored
    cpu_rd(2'b10, d); chk("div_lo", d, 8'h03);
    cpu_rd(2'b11, d); chk("div_hi", d, 8'h00);
    step();

    // First frame, also measures completion latency from frame start
    seen = 0;
    fork
      send_frame(8'hA5, 1);
      begin
        for (int i = 0; i < 1200 && !seen; i++) begin
          step();
          if (rda) begin seen = 1; lat = cyc - fstart; end
        end
      end
    join
    total++;
    assert (seen) else begin bad++; $error("FAIL a5_timeout observed=0 expected=1"); end
    model_frame(8'hA5, 1);
    chk("a5_rda", {7'b0, rda}, {7'b0, m_rda});
    rd_chk("a5_rxbuf", 2'b00);
    chk("a5_rda_clr", {7'b0, rda}, 8'h00);

    // Short low glitch is a false start
    rxd = 0; repeat (20) step(); rxd = 1;
    repeat (4 * CPB) step();
    chk("glitch_rda", {7'b0, rda}, 8'h00);
    rd_chk("glitch_status", 2'b01);

    // Framing error
    send_frame(8'h3C, 0); model_frame(8'h3C, 0);
    chk("frm_rda", {7'b0, rda}, 8'h00);
    rd_chk("frm_status1", 2'b01);
    rd_chk("frm_status2", 2'b01);

    // Overrun
    send_frame(8'h11, 1); model_frame(8'h11, 1);
    send_frame(8'h22, 1); model_frame(8'h22, 1);
    rd_chk("ovr_status", 2'b01);
    rd_chk("ovr_rxbuf", 2'b00);

    // Buffer read in the exact cycle the next frame completes
    send_frame(8'h33, 1); model_frame(8'h33, 1);
    chk("pre_al_rda", {7'b0, rda}, 8'h01);
    fork
      send_frame(8'h44, 1);
      begin
        wait (in_frame);
        while (cyc != fstart + lat - 1) step();
        cpu_rd(2'b00, d);
      end
    join
    chk("al_old_byte", d, 8'h33);
    m_rda = 0; model_frame(8'h44, 1);
    rd_chk("al_status", 2'b01);
    rd_chk("al_rxbuf", 2'b00);

    // Random frames with random processor activity in between
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      ok = ($urandom % 4) != 0;
      send_frame(b, ok); model_frame(b, ok);
      chk("rnd_rda", {7'b0, rda}, {7'b0, m_rda});
      act = $urandom % 3;
      if (act == 1) rd_chk("rnd_rxbuf", 2'b00);
      else if (act == 2) rd_chk("rnd_status", 2'b01);
    end

    // Reset in the middle of data bit 4
    send_frame(8'h99, 1); model_frame(8'h99, 1);
    rxd = 0; repeat (CPB) step();
    for (int i = 0; i < 4; i++) begin rxd = i[0]; repeat (CPB) step(); end
    rxd = 1; repeat (20) step();
    rst = 1; repeat (2) step(); rst = 0;
    m_buf = 8'h00; m_rda = 0; m_ovr = 0; m_frm = 0;
    step();
    chk("mid_rst_rda", {7'b0, rda}, 8'h00);
    rd_chk("mid_rst_rxbuf", 2'b00);
    rd_chk("mid_rst_status", 2'b01);
    cpu_rd(2'b10, d); chk("mid_rst_div", d, 8'h8A);
    cpu_wr(2'b10, 8'h03);
    cpu_wr(2'b11, 8'h00);
    repeat (8) step();
    send_frame(8'h7E, 1); model_frame(8'h7E, 1);
    chk("post_rst_rda", {7'b0, rda}, 8'h01);
    rd_chk("post_rst_rxbuf", 2'b00);
    rd_chk("post_rst_status", 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
